// File: rtl/lift_ctrl_nfloor.sv
// lift_ctrl_nfloor
//   N-floor lift controller. It latches call requests into a pending vector
//   and serves them in SCAN order: it keeps its direction while calls lie
//   ahead and reverses otherwise. Floor-to-floor travel time and door dwell
//   time are counted internally. The controller also supports a door
//   obstruction hold and an emergency stop.
//
// Ports
//   clk           rising-edge clock
//   rst           asynchronous, active-high reset
//   call_req      per-floor call request (level or pulse)
//   door_obstruct keep door open, reloads dwell timer
//   estop         emergency stop (level)
//   cur_floor     current floor index
//   dir_up        1 = up / last moved up, 0 = down
//   moving        car travelling between floors
//   door_open     door open command
//   arrive        one-cycle pulse when cur_floor changes
//   halted        high while emergency-stopped
//   call_pending  latched, unserved calls
//
// state  | meaning
// IDLE   | parked, doors closed, waiting for a call
// MOVE   | travelling one floor at a time in dir_up direction
// DOOR   | doors open at cur_floor, dwell timer running
// HALT   | emergency stop, everything frozen
module lift_ctrl_nfloor #(
  parameter int NUM_FLOORS = 4,
  parameter int MOVE_TICKS = 8,
  parameter int DOOR_TICKS = 16,
  localparam int FW   = ($clog2(NUM_FLOORS) > 1) ? $clog2(NUM_FLOORS) : 1,
  localparam int MAXT = (MOVE_TICKS > DOOR_TICKS) ? MOVE_TICKS : DOOR_TICKS,
  localparam int TW   = $clog2(MAXT + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_FLOORS-1:0] call_req,
  input  logic                  door_obstruct,
  input  logic                  estop,
  output logic [FW-1:0]         cur_floor,
  output logic                  dir_up,
  output logic                  moving,
  output logic                  door_open,
  output logic                  arrive,
  output logic                  halted,
  output logic [NUM_FLOORS-1:0] call_pending
);

  typedef enum logic [1:0] {S_IDLE, S_MOVE, S_DOOR, S_HALT} state_t;

  localparam logic [TW-1:0] MOVE_LOAD = TW'(MOVE_TICKS - 1);
  localparam logic [TW-1:0] DOOR_LOAD = TW'(DOOR_TICKS - 1);
  localparam logic [FW-1:0] TOP       = FW'(NUM_FLOORS - 1);

  state_t                state;
  logic [TW-1:0]         timer;
  logic                  above, below, ahead, behind;
  logic [FW-1:0]         next_floor;
  logic [NUM_FLOORS-1:0] cur_mask, next_mask;
  logic                  req_here;

  always_comb begin
    above = 1'b0;
    below = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (i > int'(cur_floor)) above = above | call_pending[i];
      if (i < int'(cur_floor)) below = below | call_pending[i];
    end
    ahead  = dir_up ? above : below;
    behind = dir_up ? below : above;

    // Saturate at the end floors so the car can never wrap.
    next_floor = cur_floor;
    if (dir_up && cur_floor != TOP)
      next_floor = cur_floor + FW'(1);
    else if (!dir_up && cur_floor != '0)
      next_floor = cur_floor - FW'(1);

    cur_mask             = '0;
    cur_mask[cur_floor]  = 1'b1;
    next_mask            = '0;
    next_mask[next_floor] = 1'b1;
    req_here             = call_req[cur_floor];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      timer        <= '0;
      cur_floor    <= '0;
      dir_up       <= 1'b1;
      moving       <= 1'b0;
      door_open    <= 1'b0;
      arrive       <= 1'b0;
      halted       <= 1'b0;
      call_pending <= '0;
    end else begin
      arrive <= 1'b0;
      if (state != S_HALT && estop) begin
        // Door state is held; any partial move is abandoned.
        state        <= S_HALT;
        moving       <= 1'b0;
        halted       <= 1'b1;
        call_pending <= call_pending | call_req;
      end else begin
        case (state)
          S_HALT: begin
            if (!estop) begin
              state     <= S_IDLE;
              halted    <= 1'b0;
              door_open <= 1'b0;
              timer     <= '0;
            end
          end

          S_IDLE: begin
            if (req_here || call_pending[cur_floor]) begin
              state        <= S_DOOR;
              door_open    <= 1'b1;
              timer        <= DOOR_LOAD;
              call_pending <= (call_pending | call_req) & ~cur_mask;
            end else begin
              call_pending <= call_pending | call_req;
              if (ahead || behind) begin
                state  <= S_MOVE;
                moving <= 1'b1;
                timer  <= MOVE_LOAD;
                if (!ahead) dir_up <= ~dir_up;
              end
            end
          end

          S_MOVE: begin
            if (timer == '0) begin
              cur_floor <= next_floor;
              arrive    <= (next_floor != cur_floor);
              if (call_pending[next_floor]) begin
                state        <= S_DOOR;
                moving       <= 1'b0;
                door_open    <= 1'b1;
                timer        <= DOOR_LOAD;
                // Clear beats a simultaneous new request for the same floor.
                call_pending <= (call_pending | call_req) & ~next_mask;
              end else begin
                timer        <= MOVE_LOAD;
                call_pending <= call_pending | call_req;
              end
            end else begin
              timer        <= timer - TW'(1);
              call_pending <= call_pending | call_req;
            end
          end

          S_DOOR: begin
            // A request at this floor is served by keeping the door open.
            call_pending <= call_pending | (call_req & ~cur_mask);
            if (door_obstruct || req_here) begin
              timer <= DOOR_LOAD;
            end else if (timer != '0) begin
              timer <= timer - TW'(1);
            end else begin
              door_open <= 1'b0;
              if (ahead || behind) begin
                state  <= S_MOVE;
                moving <= 1'b1;
                timer  <= MOVE_LOAD;
                if (!ahead) dir_up <= ~dir_up;
              end else begin
                state <= S_IDLE;
              end
            end
          end

          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assert property (@(posedge clk) disable iff (rst) !(moving && door_open));

endmodule

// File: tb/tb_lift_ctrl_nfloor.sv
// tb_lift_ctrl_nfloor
//   Self-checking bench for lift_ctrl_nfloor with NUM_FLOORS=4,
//   MOVE_TICKS=3, DOOR_TICKS=2. Expected arrive / door-open events are
//   queued as stimulus is applied and matched by a negedge monitor;
//   cycle-exact output values are checked directly.
module tb_lift_ctrl_nfloor;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] call_req = '0;
  logic       door_obstruct = 1'b0;
  logic       estop = 1'b0;
  logic [1:0] cur_floor;
  logic       dir_up, moving, door_open, arrive, halted;
  logic [3:0] call_pending;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int is_door;
    int floor;
  } ev_t;
  ev_t sb[$];
  logic prev_door = 1'b0;

  lift_ctrl_nfloor #(
    .NUM_FLOORS(4),
    .MOVE_TICKS(3),
    .DOOR_TICKS(2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .call_req      (call_req),
    .door_obstruct (door_obstruct),
    .estop         (estop),
    .cur_floor     (cur_floor),
    .dir_up        (dir_up),
    .moving        (moving),
    .door_open     (door_open),
    .arrive        (arrive),
    .halted        (halted),
    .call_pending  (call_pending)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_ev(input int is_door, input int floor);
    ev_t e;
    e.is_door = is_door;
    e.floor   = floor;
    sb.push_back(e);
  endtask

  task automatic pop_cmp(input int is_door);
    ev_t e;
    if (sb.size() == 0) begin
      check_val("sb_unexpected_event", is_door * 16 + int'(cur_floor), -1);
    end else begin
      e = sb.pop_front();
      check_val("sb_event", is_door * 16 + int'(cur_floor), e.is_door * 16 + e.floor);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      prev_door = 1'b0;
    end else begin
      if (arrive) pop_cmp(0);
      if (door_open && !prev_door) pop_cmp(1);
      prev_door = door_open;
    end
  end

  task automatic wait_door(input string tag, input logic lvl, input int budget);
    int n = 0;
    while (door_open !== lvl && n < budget) begin
      step(1);
      n++;
    end
    check_val(tag, int'(door_open), int'(lvl));
  endtask

  task automatic check_reset_vals(input string tag);
    check_val({tag, "_floor"},   int'(cur_floor), 0);
    check_val({tag, "_dir"},     int'(dir_up), 1);
    check_val({tag, "_moving"},  int'(moving), 0);
    check_val({tag, "_door"},    int'(door_open), 0);
    check_val({tag, "_arrive"},  int'(arrive), 0);
    check_val({tag, "_halted"},  int'(halted), 0);
    check_val({tag, "_pending"}, int'(call_pending), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(2);
    check_reset_vals("rst");
    rst = 1'b0;
  endtask

  initial begin
    int cnt;
    int mov;

    // T1: single call to floor 2, exact cycle timing
    step(1);
    do_reset();
    call_req = 4'b0100;
    expect_ev(0, 1);
    expect_ev(0, 2);
    expect_ev(1, 2);
    step(1);                                      // edge 0
    call_req = '0;
    check_val("t1_latched", int'(call_pending), 4);
    check_val("t1_not_moving_e0", int'(moving), 0);
    step(1);                                      // edge 1
    check_val("t1_moving_e1", int'(moving), 1);
    step(2);                                      // edge 3
    check_val("t1_floor_e3", int'(cur_floor), 0);
    step(1);                                      // edge 4
    check_val("t1_floor_e4", int'(cur_floor), 1);
    check_val("t1_arrive_e4", int'(arrive), 1);
    step(3);                                      // edge 7
    check_val("t1_floor_e7", int'(cur_floor), 2);
    check_val("t1_arrive_e7", int'(arrive), 1);
    check_val("t1_door_e7", int'(door_open), 1);
    check_val("t1_moving_e7", int'(moving), 0);
    check_val("t1_pending_e7", int'(call_pending), 0);
    step(1);                                      // edge 8
    check_val("t1_door_e8", int'(door_open), 1);
    check_val("t1_arrive_e8", int'(arrive), 0);
    step(1);                                      // edge 9
    check_val("t1_door_e9", int'(door_open), 0);
    check_val("t1_idle_e9", int'(moving), 0);

    // T2: calls 3 and 0 together from floor 2 going up
    call_req = 4'b1001;
    expect_ev(0, 3);
    expect_ev(1, 3);
    expect_ev(0, 2);
    expect_ev(0, 1);
    expect_ev(0, 0);
    expect_ev(1, 0);
    step(1);
    call_req = '0;
    check_val("t2_latched", int'(call_pending), 9);
    step(1);
    check_val("t2_moving", int'(moving), 1);
    check_val("t2_dir_kept", int'(dir_up), 1);
    wait_door("t2_door3_open", 1'b1, 50);
    check_val("t2_at3", int'(cur_floor), 3);
    check_val("t2_pending_after3", int'(call_pending), 1);
    wait_door("t2_door3_close", 1'b0, 50);
    wait_door("t2_door0_open", 1'b1, 50);
    check_val("t2_at0", int'(cur_floor), 0);
    check_val("t2_dir_down", int'(dir_up), 0);
    check_val("t2_pending_clear", int'(call_pending), 0);
    wait_door("t2_door0_close", 1'b0, 50);
    check_val("t2_idle", int'(moving), 0);
    check_val("t2_sb_empty", sb.size(), 0);

    // T3: door obstruction at floor 1
    call_req = 4'b0010;
    expect_ev(0, 1);
    expect_ev(1, 1);
    step(1);
    call_req = '0;
    wait_door("t3_door_open", 1'b1, 50);
    check_val("t3_at1", int'(cur_floor), 1);
    door_obstruct = 1'b1;
    cnt = 1;
    mov = 0;
    for (int k = 1; k <= 20; k++) begin
      step(1);
      if (k == 5) door_obstruct = 1'b0;
      if (!door_open) break;
      cnt++;
      mov = mov | int'(moving);
    end
    check_val("t3_door_cycles", cnt, 7);
    check_val("t3_no_moving", mov, 0);
    check_val("t3_sb_empty", sb.size(), 0);

    // T4: estop mid-travel from floor 0 towards floor 3
    do_reset();
    call_req = 4'b1000;
    expect_ev(0, 1);
    expect_ev(0, 2);
    expect_ev(0, 3);
    expect_ev(1, 3);
    step(1);                                      // edge 0
    call_req = '0;
    step(1);                                      // edge 1
    check_val("t4_moving", int'(moving), 1);
    step(4);                                      // edge 5
    check_val("t4_floor_e5", int'(cur_floor), 1);
    estop = 1'b1;
    step(1);                                      // edge 6
    check_val("t4_halted", int'(halted), 1);
    check_val("t4_halt_moving", int'(moving), 0);
    call_req = 4'b0101;
    step(3);                                      // edge 9
    check_val("t4_halt_floor", int'(cur_floor), 1);
    check_val("t4_halt_still", int'(halted), 1);
    check_val("t4_halt_pending", int'(call_pending), 8);
    check_val("t4_halt_door", int'(door_open), 0);
    call_req = '0;
    estop = 1'b0;
    step(1);                                      // edge 10
    check_val("t4_released", int'(halted), 0);
    check_val("t4_rel_moving", int'(moving), 0);
    step(1);                                      // edge 11
    check_val("t4_resume", int'(moving), 1);
    step(3);                                      // edge 14
    check_val("t4_floor_e14", int'(cur_floor), 2);
    step(3);                                      // edge 17
    check_val("t4_floor_e17", int'(cur_floor), 3);
    check_val("t4_door_e17", int'(door_open), 1);
    check_val("t4_pending_e17", int'(call_pending), 0);
    wait_door("t4_door_close", 1'b0, 20);
    check_val("t4_dir_up_at_top", int'(dir_up), 1);

    // T5: at top going up, call floor 0
    call_req = 4'b0001;
    expect_ev(0, 2);
    expect_ev(0, 1);
    expect_ev(0, 0);
    expect_ev(1, 0);
    step(1);
    call_req = '0;
    step(1);
    check_val("t5_dir_flip", int'(dir_up), 0);
    check_val("t5_moving", int'(moving), 1);
    check_val("t5_floor", int'(cur_floor), 3);
    wait_door("t5_door_open", 1'b1, 50);
    check_val("t5_at0", int'(cur_floor), 0);
    wait_door("t5_door_close", 1'b0, 20);
    check_val("t5_sb_empty", sb.size(), 0);

    // T6: asynchronous reset while the door is open with calls pending
    call_req = 4'b0100;
    expect_ev(0, 1);
    expect_ev(0, 2);
    expect_ev(1, 2);
    step(1);
    call_req = '0;
    wait_door("t6_door_open", 1'b1, 50);
    check_val("t6_at2", int'(cur_floor), 2);
    call_req = 4'b1010;
    step(1);
    call_req = '0;
    check_val("t6_pending_set", int'(call_pending), 10);
    check_val("t6_door_still", int'(door_open), 1);
    check_val("t6_sb_empty", sb.size(), 0);
    #2 rst = 1'b1;
    #1 check_reset_vals("t6_async");
    step(2);
    rst = 1'b0;
    step(5);
    check_val("t6_post_moving", int'(moving), 0);
    check_val("t6_post_pending", int'(call_pending), 0);
    check_val("t6_post_floor", int'(cur_floor), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
